data_store_buffer: RTL and testbench

//  Posted-write store buffer between the MainProcessor memory port (DataAdr/writeData/memwrite)
//  and the single-port DataMemory. Stores retire into a DEPTH-entry FIFO in one cycle.
//  The FIFO drains to memory on cycles with no load. Loads get store-to-load forwarding

---
 rtl/data_store_buffer.sv | 119 +++++++++++
 tb/tb_data_store_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the CPU memory port and a single-port data memory.
// Optional STB_COALESCE_EN: stores to an already-buffered address merge into that entry.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic          cpu_fence,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] entAddr [DEPTH];
  logic [DW-1:0] entData [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] count;

  logic          loadAct;
  logic          drainAct;
  logic          pushAct;
  logic          fenceStall;
  logic          fullStall;
  logic          coalesce;
  logic          fwdHit;
  logic [DW-1:0] fwdData;
  logic [PW-1:0] idx;
`ifdef STB_COALESCE_EN
  logic          coalHit;
  logic [PW-1:0] coalIdx;
`endif

  // Port arbitration, forwarding and stall decisions for this cycle
  always_comb begin
    loadAct    = cpu_re & ~cpu_we & ~reset;
    drainAct   = ~reset & ~loadAct & (count != '0);
    fenceStall = ~reset & cpu_fence & (count != '0);
    fwdHit     = 1'b0;
    fwdData    = '0;
    idx        = '0;
`ifdef STB_COALESCE_EN
    coalHit    = 1'b0;
    coalIdx    = '0;
`endif
    // Walk oldest to youngest so the last match is the youngest entry
    for (int k = 0; k < DEPTH; k++) begin
      idx = headPtr + PW'(k);
      if ((CW'(k) < count) && (entAddr[idx] == cpu_addr)) begin
        fwdHit  = 1'b1;
        fwdData = entData[idx];
`ifdef STB_COALESCE_EN
        // The head leaving this cycle cannot absorb a new store
        if (!((k == 0) && drainAct)) begin
          coalHit = 1'b1;
          coalIdx = idx;
        end
`endif
      end
    end
`ifdef STB_COALESCE_EN
    coalesce = ~reset & cpu_we & ~fenceStall & coalHit;
`else
    coalesce = 1'b0;
`endif
    fullStall = ~reset & cpu_we & (count == CW'(DEPTH)) & ~coalesce;
    pushAct   = ~reset & cpu_we & ~fenceStall & ~fullStall & ~coalesce;
    cpu_stall = fenceStall | fullStall;
    cpu_rdata = loadAct ? (fwdHit ? fwdData : mem_rdata) : '0;
    mem_we    = drainAct;
    mem_addr  = '0;
    mem_wdata = '0;
    if (loadAct) begin
      mem_addr = cpu_addr;
    end else if (drainAct) begin
      mem_addr  = entAddr[headPtr];
      mem_wdata = entData[headPtr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pushAct)  tailPtr <= tailPtr + 1'b1;
      if (drainAct) headPtr <= headPtr + 1'b1;
      count <= count + CW'(pushAct) - CW'(drainAct);
    end
  end

  // Entry storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (pushAct) begin
      entAddr[tailPtr] <= cpu_addr;
      entData[tailPtr] <= cpu_wdata;
    end
`ifdef STB_COALESCE_EN
    if (coalesce) entData[coalIdx] <= cpu_wdata;
`endif
  end

  assign sb_empty = (count == '0);

endmodule

// File: tb/tb_data_store_buffer.sv
// Bench for data_store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_fence;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        sb_empty;

  data_store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_fence(cpu_fence),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Data memory driven by the DUT (256 words, address aliased on low byte)
  logic [15:0] benchMem [256] = '{default: 16'h0};
  always @(posedge clk) if (mem_we) benchMem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = benchMem[mem_addr[7:0]];

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] shadow [256] = '{default: 16'h0};
  int          total = 0;
  int          bad = 0;

  logic [15:0] sRdata;
  logic [15:0] sMemAddr;
  logic        sMemWe;
  logic        sStall;
  logic        sEmpty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step(input bit rst, input bit we, input bit re, input bit fe,
                      input logic [15:0] a, input logic [15:0] d);
    bit ld, dr, fs, st, co, fwd, push;
    int ci;
    logic [15:0] eRd, eAddr, eWd, fd;
    @(negedge clk);
    reset = rst; cpu_we = we; cpu_re = re; cpu_fence = fe;
    cpu_addr = a; cpu_wdata = d;
    #1;
    ld = 0; dr = 0; fs = 0; st = 0; co = 0; push = 0; ci = -1;
    eRd = 16'h0; eAddr = 16'h0; eWd = 16'h0;
    if (!rst) begin
      ld = re && !we;
      dr = !ld && (q.size() > 0);
      fs = fe && (q.size() > 0);
      fwd = 0; fd = 16'h0;
      foreach (q[i]) if (q[i].a == a) begin fwd = 1; fd = q[i].d; end
`ifdef STB_COALESCE_EN
      if (we && !fs)
        foreach (q[i]) if (q[i].a == a && !(i == 0 && dr)) ci = i;
      co = (ci >= 0);
`endif
      st = fs || (we && !co && q.size() == DEPTH);
      push = we && !st && !co;
      if (ld) begin
        eRd = fwd ? fd : shadow[a[7:0]];
        eAddr = a;
      end else if (dr) begin
        eAddr = q[0].a;
        eWd = q[0].d;
      end
    end
    sRdata = cpu_rdata; sMemAddr = mem_addr; sMemWe = mem_we;
    sStall = cpu_stall; sEmpty = sb_empty;
    chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    chk("cpu_stall", 32'(cpu_stall), 32'(st));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(eRd));
    chk("mem_we", 32'(mem_we), 32'(dr));
    chk("mem_addr", 32'(mem_addr), 32'(eAddr));
    if (!ld) chk("mem_wdata", 32'(mem_wdata), 32'(eWd));
    if (rst) begin
      q.delete();
    end else begin
      if (co) q[ci].d = d;
      if (dr) begin
        shadow[q[0].a[7:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (push) q.push_back('{a: a, d: d});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [6:0]  weSeq;
    logic [15:0] firstDrain;
    logic [15:0] ra;
    int          r;
    int          memBad;

    reset = 1; cpu_we = 0; cpu_re = 0; cpu_fence = 0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);

    // Reset state; a store presented during reset is dropped
    step(1, 1, 0, 0, 16'h0055, 16'h9999);
    chk("rst_empty", 32'(sEmpty), 32'd1);
    chk("rst_memwe", 32'(sMemWe), 32'd0);
    chk("rst_stall", 32'(sStall), 32'd0);
    idle();
    chk("rst_store_dropped", 32'(sEmpty), 32'd1);

    // Store then load the same address: forwarded with zero latency
    step(0, 1, 0, 0, 16'h0010, 16'h1234);
    step(0, 0, 1, 0, 16'h0010, 16'h0000);
    chk("fwd_data", 32'(sRdata), 32'h1234);
    chk("fwd_memwe", 32'(sMemWe), 32'd0);
    idle(); idle();

    // Five back-to-back stores drain in order, one cycle behind
    weSeq = '0; firstDrain = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(0, 1, 0, 0, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
      else idle();
      weSeq[i] = sMemWe;
      if (i == 1) firstDrain = sMemAddr;
      chk("b2b_nostall", 32'(sStall), 32'd0);
    end
    chk("b2b_memwe_seq", 32'(weSeq), 32'b0111110);
    chk("b2b_first_addr", 32'(firstDrain), 32'h0100);
    chk("b2b_last_data", 32'(benchMem[8'h04]), 32'hA004);

    // Two stores to one address: load returns the younger value
    step(0, 1, 0, 0, 16'h0020, 16'h0001);
    step(0, 1, 0, 0, 16'h0020, 16'h0002);
    step(0, 0, 1, 0, 16'h0020, 16'h0000);
    chk("dup_load", 32'(sRdata), 32'h0002);
    idle(); idle();
    chk("dup_mem", 32'(benchMem[8'h20]), 32'h0002);

    // Fence stalls until the buffer has drained
    step(0, 1, 0, 0, 16'h0030, 16'h0007);
    step(0, 0, 0, 1, 16'h0000, 16'h0000);
    chk("fence_stall", 32'(sStall), 32'd1);
    step(0, 0, 0, 1, 16'h0000, 16'h0000);
    chk("fence_release", 32'(sStall), 32'd0);
    chk("fence_empty", 32'(sEmpty), 32'd1);

    // Reset with a buffered store: memory keeps its old value
    step(0, 1, 0, 0, 16'h0040, 16'hBEEF);
    step(1, 0, 0, 0, 16'h0000, 16'h0000);
    idle(); idle();
    chk("rst_discard_mem", 32'(benchMem[8'h40]), 32'h0000);
    chk("rst_discard_empty", 32'(sEmpty), 32'd1);

    // Randomized traffic; upper address bit varies to exercise full-width compare
    for (int n = 0; n < 3000; n++) begin
      r  = int'($urandom_range(0, 99));
      ra = {($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00, 8'($urandom_range(0, 7))};
      step(($urandom_range(0, 299) == 0), (r < 40), (r >= 30 && r < 75),
           ($urandom_range(0, 15) == 0), ra, 16'($urandom()));
    end
    repeat (DEPTH + 2) idle();

    memBad = 0;
    for (int i = 0; i < 256; i++) if (benchMem[i] !== shadow[i]) memBad++;
    chk("final_memory", 32'(memBad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
